// File: rtl/exmem_stage.sv
// ---------------------------------------------------------------------------
// exmem_stage -- EX/MEM pipeline register
//
// Sits downstream of the ALU. Captures the ALU result, store data and
// write-back control. Holds the architectural NZVC flags register. Resolves
// B.cond / CBZ / CBNZ into a registered branch_taken. Feeds the memory stage.
//
// Per-edge priority: rst > flush > stall > load. A load with in_valid=0
// inserts a bubble exactly like a flush. A bubble clears every control
// output. It leaves the data registers and flags_q unchanged.
//
// Parameters
//   WORDSIZE   datapath width
//   REGBITS    register-address width
//   CNTBITS    branch statistics counter width (BRANCH_STATS_EN only)
//
// Ports
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   in_valid, stall, flush    stage control
//   alu_res, alu_flags        ALU result and {N,Z,V,C}
//   setflags                  instruction writes NZVC
//   is_bcond, cond            B.cond and its ARM condition code
//   is_cbz, is_cbnz           compare-and-branch (Z of alu_flags decides)
//   target_in                 precomputed branch target
//   store_in, rd_in           store data, destination register
//   regwrite_in, memread_in, memwrite_in   write-back / memory control
//   out_*                     registered stage contents (controls gated by valid)
//   branch_taken, branch_target           registered branch resolution
//   flags_q                   architectural NZVC register
//   br_count, br_taken_count  branch statistics (BRANCH_STATS_EN only)
//
// Configuration macro: BRANCH_STATS_EN
// ---------------------------------------------------------------------------
module exmem_stage #(
  parameter int unsigned WORDSIZE = 64,
  parameter int unsigned REGBITS  = 5,
  parameter int unsigned CNTBITS  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                stall,
  input  logic                flush,
  input  logic [WORDSIZE-1:0] alu_res,
  input  logic [3:0]          alu_flags,
  input  logic                setflags,
  input  logic                is_bcond,
  input  logic [3:0]          cond,
  input  logic                is_cbz,
  input  logic                is_cbnz,
  input  logic [WORDSIZE-1:0] target_in,
  input  logic [WORDSIZE-1:0] store_in,
  input  logic [REGBITS-1:0]  rd_in,
  input  logic                regwrite_in,
  input  logic                memread_in,
  input  logic                memwrite_in,
  output logic                out_valid,
  output logic [WORDSIZE-1:0] out_res,
  output logic [WORDSIZE-1:0] out_store,
  output logic [REGBITS-1:0]  out_rd,
  output logic                out_regwrite,
  output logic                out_memread,
  output logic                out_memwrite,
  output logic                branch_taken,
  output logic [WORDSIZE-1:0] branch_target,
  output logic [3:0]          flags_q
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNTBITS-1:0]  br_count,
  output logic [CNTBITS-1:0]  br_taken_count
`endif
);

  // Elaboration-time parameter sanity
  if (WORDSIZE == 0 || REGBITS == 0 || CNTBITS == 0) begin : g_param_check
    $error("exmem_stage: WORDSIZE, REGBITS and CNTBITS must be nonzero");
  end

  // Flag bit positions inside {N,Z,V,C}
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_C = 0;

  // What the stage does on the coming edge (reset handled in the register)
  typedef enum logic [1:0] {
    ACT_HOLD   = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_LOAD   = 2'd2
  } action_e;

  // ARM condition codes, grouped in pairs: the odd member negates the even one
  typedef enum logic [2:0] {
    CP_EQ_NE = 3'd0,
    CP_HS_LO = 3'd1,
    CP_MI_PL = 3'd2,
    CP_VS_VC = 3'd3,
    CP_HI_LS = 3'd4,
    CP_GE_LT = 3'd5,
    CP_GT_LE = 3'd6,
    CP_AL_NV = 3'd7
  } cond_pair_e;

  // Evaluate condition code c against flags f
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, v, cy, base;
    n  = f[FLAG_N];
    z  = f[FLAG_Z];
    v  = f[FLAG_V];
    cy = f[FLAG_C];
    case (cond_pair_e'(c[3:1]))
      CP_EQ_NE: base = z;
      CP_HS_LO: base = cy;
      CP_MI_PL: base = n;
      CP_VS_VC: base = v;
      CP_HI_LS: base = cy & ~z;
      CP_GE_LT: base = (n == v);
      CP_GT_LE: base = ~z & (n == v);
      default:  base = 1'b1;
    endcase
    // 0xE and 0xF are both "always": the pair is not inverted
    if (c[0] && (cond_pair_e'(c[3:1]) != CP_AL_NV)) begin
      return ~base;
    end
    return base;
  endfunction

  action_e               action_c;
  logic                  is_branch_c;
  logic                  taken_c;

  logic                  valid_d;
  logic [WORDSIZE-1:0]   res_d;
  logic [WORDSIZE-1:0]   store_d;
  logic [REGBITS-1:0]    rd_d;
  logic                  regwrite_d;
  logic                  memread_d;
  logic                  memwrite_d;
  logic                  taken_d;
  logic [WORDSIZE-1:0]   target_d;
  logic [3:0]            flags_d;

  // Stage action from flush/stall/in_valid
  always_comb begin
    action_c = ACT_LOAD;
    if (flush) begin
      action_c = ACT_BUBBLE;
    end else if (stall) begin
      action_c = ACT_HOLD;
    end else if (!in_valid) begin
      action_c = ACT_BUBBLE;
    end
  end

  // Branch resolution; B.cond reads the flags before this instruction updates them
  always_comb begin
    is_branch_c = is_bcond | is_cbz | is_cbnz;
    taken_c     = (is_cbz   &  alu_flags[FLAG_Z])
                | (is_cbnz  & ~alu_flags[FLAG_Z])
                | (is_bcond &  cond_pass(cond, flags_q));
  end

  // Next-state for the stage registers
  always_comb begin
    valid_d    = out_valid;
    res_d      = out_res;
    store_d    = out_store;
    rd_d       = out_rd;
    regwrite_d = out_regwrite;
    memread_d  = out_memread;
    memwrite_d = out_memwrite;
    taken_d    = branch_taken;
    target_d   = branch_target;
    flags_d    = flags_q;

    case (action_c)
      ACT_BUBBLE: begin
        valid_d    = 1'b0;
        regwrite_d = 1'b0;
        memread_d  = 1'b0;
        memwrite_d = 1'b0;
        taken_d    = 1'b0;
      end
      ACT_LOAD: begin
        valid_d    = 1'b1;
        res_d      = alu_res;
        store_d    = store_in;
        rd_d       = rd_in;
        regwrite_d = regwrite_in;
        memread_d  = memread_in;
        memwrite_d = memwrite_in;
        taken_d    = taken_c;
        target_d   = target_in;
        if (setflags) begin
          flags_d = alu_flags;
        end
      end
      default: begin
      end
    endcase
  end

  // Stage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_res       <= '0;
      out_store     <= '0;
      out_rd        <= '0;
      out_regwrite  <= 1'b0;
      out_memread   <= 1'b0;
      out_memwrite  <= 1'b0;
      branch_taken  <= 1'b0;
      branch_target <= '0;
      flags_q       <= '0;
    end else begin
      out_valid     <= valid_d;
      out_res       <= res_d;
      out_store     <= store_d;
      out_rd        <= rd_d;
      out_regwrite  <= regwrite_d;
      out_memread   <= memread_d;
      out_memwrite  <= memwrite_d;
      branch_taken  <= taken_d;
      branch_target <= target_d;
      flags_q       <= flags_d;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [CNTBITS-1:0] br_count_d;
  logic [CNTBITS-1:0] br_taken_count_d;

  // Count loaded valid branches and the taken subset; wrap naturally
  always_comb begin
    br_count_d       = br_count;
    br_taken_count_d = br_taken_count;
    if (action_c == ACT_LOAD && is_branch_c) begin
      br_count_d = br_count + CNTBITS'(1);
      if (taken_c) begin
        br_taken_count_d = br_taken_count + CNTBITS'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_count       <= '0;
      br_taken_count <= '0;
    end else begin
      br_count       <= br_count_d;
      br_taken_count <= br_taken_count_d;
    end
  end
`else
  logic unused_branch_c;
  assign unused_branch_c = is_branch_c;
`endif

endmodule

// File: tb/tb_exmem_stage.sv
// ---------------------------------------------------------------------------
// tb_exmem_stage -- self-checking bench for exmem_stage
//
// Directed scenarios plus a randomized run compared against a behavioural
// model of the stage. Define BRANCH_STATS_EN to also cover the statistics
// counters. That build uses a narrow counter so the wrap is reachable.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_exmem_stage;

  localparam int unsigned WS = 64;
  localparam int unsigned RB = 5;
`ifdef BRANCH_STATS_EN
  localparam int unsigned CB = 4;
`else
  localparam int unsigned CB = 32;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, stall, flush, setflags, is_bcond, is_cbz, is_cbnz;
  logic          regwrite_in, memread_in, memwrite_in;
  logic [WS-1:0] alu_res, target_in, store_in;
  logic [3:0]    alu_flags, cond;
  logic [RB-1:0] rd_in;
  logic          out_valid, out_regwrite, out_memread, out_memwrite, branch_taken;
  logic [WS-1:0] out_res, out_store, branch_target;
  logic [RB-1:0] out_rd;
  logic [3:0]    flags_q;
`ifdef BRANCH_STATS_EN
  logic [CB-1:0] br_count, br_taken_count;
  logic [CB-1:0] m_brc, m_brt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  logic          m_valid, m_rw, m_mr, m_mw, m_taken;
  logic [WS-1:0] m_res, m_store, m_target;
  logic [RB-1:0] m_rd;
  logic [3:0]    m_flags;

  exmem_stage #(.WORDSIZE(WS), .REGBITS(RB), .CNTBITS(CB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .alu_res(alu_res), .alu_flags(alu_flags), .setflags(setflags),
    .is_bcond(is_bcond), .cond(cond), .is_cbz(is_cbz), .is_cbnz(is_cbnz),
    .target_in(target_in), .store_in(store_in), .rd_in(rd_in),
    .regwrite_in(regwrite_in), .memread_in(memread_in), .memwrite_in(memwrite_in),
    .out_valid(out_valid), .out_res(out_res), .out_store(out_store), .out_rd(out_rd),
    .out_regwrite(out_regwrite), .out_memread(out_memread), .out_memwrite(out_memwrite),
    .branch_taken(branch_taken), .branch_target(branch_target), .flags_q(flags_q)
`ifdef BRANCH_STATS_EN
    , .br_count(br_count), .br_taken_count(br_taken_count)
`endif
  );

  always #5 clk = ~clk;

  // Condition table written out one code at a time
  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, v, cy;
    n = f[3]; z = f[2]; v = f[1]; cy = f[0];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !(cy && !z);
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return !(!z && (n == v));
      default: return 1'b1;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs currently applied
  task automatic model_edge();
    bit br, tk;
    if (rst) begin
      m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_taken = 0;
      m_res = '0; m_store = '0; m_target = '0; m_rd = '0; m_flags = '0;
`ifdef BRANCH_STATS_EN
      m_brc = '0; m_brt = '0;
`endif
    end else if (flush || (!stall && !in_valid)) begin
      m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_taken = 0;
    end else if (!stall) begin
      br = is_bcond || is_cbz || is_cbnz;
      if (is_cbz)        tk = alu_flags[2];
      else if (is_cbnz)  tk = !alu_flags[2];
      else if (is_bcond) tk = cond_holds(cond, m_flags);
      else               tk = 0;
      m_valid = 1; m_res = alu_res; m_store = store_in; m_rd = rd_in;
      m_rw = regwrite_in; m_mr = memread_in; m_mw = memwrite_in;
      m_taken = tk; m_target = target_in;
      if (setflags) m_flags = alu_flags;
`ifdef BRANCH_STATS_EN
      if (br) begin
        m_brc = m_brc + 1'b1;
        if (tk) m_brt = m_brt + 1'b1;
      end
`else
      if (br) begin end
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    rst = 0; in_valid = 0; stall = 0; flush = 0; setflags = 0;
    is_bcond = 0; is_cbz = 0; is_cbnz = 0; cond = '0; alu_flags = '0;
    regwrite_in = 0; memread_in = 0; memwrite_in = 0;
    alu_res = '0; target_in = '0; store_in = '0; rd_in = '0;
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 1; stall = 1; flush = 1; setflags = 1;
    is_bcond = 1; is_cbz = 1; is_cbnz = 1; cond = 4'hF; alu_flags = 4'hF;
    regwrite_in = 1; memread_in = 1; memwrite_in = 1;
    alu_res = '1; target_in = '1; store_in = '1; rd_in = '1;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0h exp=0", out_valid); end
    n_checks++; if (out_res !== '0) begin n_fail++; $display("FAIL reset_res got=%0h exp=0", out_res); end
    n_checks++; if (out_store !== '0) begin n_fail++; $display("FAIL reset_store got=%0h exp=0", out_store); end
    n_checks++; if (out_rd !== '0) begin n_fail++; $display("FAIL reset_rd got=%0h exp=0", out_rd); end
    n_checks++; if ({out_regwrite, out_memread, out_memwrite} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl got=%0b exp=000", {out_regwrite, out_memread, out_memwrite}); end
    n_checks++; if (branch_taken !== 1'b0) begin n_fail++; $display("FAIL reset_taken got=%0h exp=0", branch_taken); end
    n_checks++; if (branch_target !== '0) begin n_fail++; $display("FAIL reset_target got=%0h exp=0", branch_target); end
    n_checks++; if (flags_q !== 4'h0) begin n_fail++; $display("FAIL reset_flags got=%0h exp=0", flags_q); end
`ifdef BRANCH_STATS_EN
    n_checks++; if ({br_count, br_taken_count} !== '0) begin
      n_fail++; $display("FAIL reset_stats got=%0h/%0h exp=0/0", br_count, br_taken_count); end
`endif
    clear_inputs();
  endtask

  task automatic test_setflags_bcond();
    in_valid = 1; setflags = 1; alu_flags = 4'b0100; regwrite_in = 1; rd_in = 5'd3;
    alu_res = 64'h0123_4567_89AB_CDEF;
    tick();
    n_checks++; if (flags_q !== 4'b0100) begin n_fail++; $display("FAIL subs_flags got=%0b exp=0100", flags_q); end
    n_checks++; if ({out_valid, out_regwrite, out_rd} !== {1'b1, 1'b1, 5'd3}) begin
      n_fail++; $display("FAIL subs_ctrl got=%0b/%0b/%0d exp=1/1/3", out_valid, out_regwrite, out_rd); end
    n_checks++; if (out_res !== 64'h0123_4567_89AB_CDEF) begin n_fail++; $display("FAIL subs_res got=%0h", out_res); end
    clear_inputs();
    in_valid = 1; is_bcond = 1; cond = 4'h0; target_in = 64'h1000;
    tick();
    n_checks++; if (branch_taken !== 1'b1) begin n_fail++; $display("FAIL beq_taken got=%0b exp=1", branch_taken); end
    n_checks++; if (branch_target !== 64'h1000) begin n_fail++; $display("FAIL beq_target got=%0h exp=1000", branch_target); end
    // Branch that also writes flags: decision uses the pre-update flags
    clear_inputs();
    in_valid = 1; is_bcond = 1; cond = 4'h0; setflags = 1; alu_flags = 4'b0000;
    tick();
    n_checks++; if ({branch_taken, flags_q} !== 5'b1_0000) begin
      n_fail++; $display("FAIL bcond_preflags got=%0b/%0b exp=1/0000", branch_taken, flags_q); end
    clear_inputs();
    in_valid = 1; is_bcond = 1; cond = 4'h0;
    tick();
    n_checks++; if (branch_taken !== 1'b0) begin n_fail++; $display("FAIL beq_nottaken got=%0b exp=0", branch_taken); end
    clear_inputs();
  endtask

  task automatic test_stall();
    in_valid = 1; setflags = 1; alu_flags = 4'b0010; alu_res = 64'hAA; rd_in = 5'd7; regwrite_in = 1;
    tick();
    clear_inputs();
    stall = 1; in_valid = 1; setflags = 1; alu_flags = 4'b1000; alu_res = 64'h55;
    rd_in = 5'd9; memwrite_in = 1; regwrite_in = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (flags_q !== 4'b0010) begin n_fail++; $display("FAIL stall_flags cyc=%0d got=%0b exp=0010", i, flags_q); end
      n_checks++; if ({out_valid, out_regwrite, out_memwrite, out_rd, out_res} !== {3'b110, 5'd7, 64'hAA}) begin
        n_fail++; $display("FAIL stall_hold cyc=%0d got=%0b%0b%0b/%0d/%0h exp=110/7/aa",
                           i, out_valid, out_regwrite, out_memwrite, out_rd, out_res); end
    end
    clear_inputs();
  endtask

  task automatic test_flush();
    flush = 1; stall = 1; in_valid = 1; memwrite_in = 1; setflags = 1; alu_flags = 4'hF;
    is_cbnz = 1;
    tick();
    n_checks++; if ({out_valid, out_memwrite, branch_taken} !== 3'b000) begin
      n_fail++; $display("FAIL flush_ctrl got=%0b%0b%0b exp=000", out_valid, out_memwrite, branch_taken); end
    n_checks++; if (flags_q !== 4'b0010) begin n_fail++; $display("FAIL flush_flags got=%0b exp=0010", flags_q); end
    clear_inputs();
  endtask

  task automatic test_bubble();
    in_valid = 1; regwrite_in = 1; memread_in = 1;
    tick();
    in_valid = 0;
    tick();
    n_checks++; if ({out_valid, out_regwrite, out_memread} !== 3'b000) begin
      n_fail++; $display("FAIL bubble_ctrl got=%0b%0b%0b exp=000", out_valid, out_regwrite, out_memread); end
    clear_inputs();
  endtask

  task automatic test_cbz_cbnz();
    in_valid = 1; is_cbnz = 1; alu_res = 64'd0; alu_flags = 4'b0100;
    tick();
    n_checks++; if (branch_taken !== 1'b0) begin n_fail++; $display("FAIL cbnz_zero got=%0b exp=0", branch_taken); end
    alu_res = 64'd5; alu_flags = 4'b0000;
    tick();
    n_checks++; if (branch_taken !== 1'b1) begin n_fail++; $display("FAIL cbnz_nonzero got=%0b exp=1", branch_taken); end
    is_cbnz = 0; is_cbz = 1; alu_res = 64'd0; alu_flags = 4'b0100;
    tick();
    n_checks++; if (branch_taken !== 1'b1) begin n_fail++; $display("FAIL cbz_zero got=%0b exp=1", branch_taken); end
    alu_res = 64'd9; alu_flags = 4'b0000;
    tick();
    n_checks++; if (branch_taken !== 1'b0) begin n_fail++; $display("FAIL cbz_nonzero got=%0b exp=0", branch_taken); end
    n_checks++; if (flags_q !== 4'b0010) begin n_fail++; $display("FAIL cbz_flags got=%0b exp=0010", flags_q); end
    clear_inputs();
  endtask

  task automatic test_conds();
    logic [3:0] f;
    bit exp;
    for (int c = 0; c < 16; c++) begin
      for (int k = 0; k < 4; k++) begin
        f = 4'($urandom);
        clear_inputs();
        in_valid = 1; setflags = 1; alu_flags = f;
        tick();
        clear_inputs();
        in_valid = 1; is_bcond = 1; cond = 4'(c); alu_flags = ~f;
        tick();
        exp = cond_holds(4'(c), f);
        n_checks++; if (branch_taken !== exp) begin
          n_fail++; $display("FAIL cond_%0h flags=%0b got=%0b exp=%0b", c, f, branch_taken, exp); end
      end
    end
    clear_inputs();
  endtask

  task automatic test_random();
    int kind;
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 99) < 2);
      flush    = ($urandom_range(0, 99) < 10);
      stall    = ($urandom_range(0, 99) < 20);
      in_valid = ($urandom_range(0, 99) < 80);
      setflags = $urandom_range(0, 1);
      kind     = $urandom_range(0, 3);
      is_bcond = (kind == 1); is_cbz = (kind == 2); is_cbnz = (kind == 3);
      cond = 4'($urandom); alu_flags = 4'($urandom);
      regwrite_in = $urandom_range(0, 1); memread_in = $urandom_range(0, 1);
      memwrite_in = $urandom_range(0, 1);
      alu_res = {$urandom, $urandom}; store_in = {$urandom, $urandom};
      target_in = {$urandom, $urandom}; rd_in = 5'($urandom);
      tick();
      n_checks++; if ({out_valid, out_regwrite, out_memread, out_memwrite, branch_taken} !==
                      {m_valid, m_rw, m_mr, m_mw, m_taken}) begin
        n_fail++; $display("FAIL rand_ctrl cyc=%0d got=%0b exp=%0b", i,
          {out_valid, out_regwrite, out_memread, out_memwrite, branch_taken},
          {m_valid, m_rw, m_mr, m_mw, m_taken}); end
      n_checks++; if (flags_q !== m_flags) begin
        n_fail++; $display("FAIL rand_flags cyc=%0d got=%0b exp=%0b", i, flags_q, m_flags); end
      if (m_valid) begin
        n_checks++; if ({out_res, out_store, out_rd, branch_target} !== {m_res, m_store, m_rd, m_target}) begin
          n_fail++; $display("FAIL rand_data cyc=%0d got=%0h/%0h/%0d/%0h exp=%0h/%0h/%0d/%0h", i,
            out_res, out_store, out_rd, branch_target, m_res, m_store, m_rd, m_target); end
      end
`ifdef BRANCH_STATS_EN
      n_checks++; if ({br_count, br_taken_count} !== {m_brc, m_brt}) begin
        n_fail++; $display("FAIL rand_stats cyc=%0d got=%0h/%0h exp=%0h/%0h", i,
          br_count, br_taken_count, m_brc, m_brt); end
`endif
    end
    clear_inputs();
  endtask

`ifdef BRANCH_STATS_EN
  task automatic test_stats();
    rst = 1;
    tick();
    clear_inputs();
    // flags_q is zero, so B.EQ is never taken
    in_valid = 1; is_bcond = 1; cond = 4'h0;
    for (int i = 0; i < 15; i++) tick();
    n_checks++; if ({br_count, br_taken_count} !== {4'hF, 4'h0}) begin
      n_fail++; $display("FAIL stats_count got=%0h/%0h exp=f/0", br_count, br_taken_count); end
    stall = 1; cond = 4'hE;
    tick();
    flush = 1;
    tick();
    n_checks++; if ({br_count, br_taken_count} !== {4'hF, 4'h0}) begin
      n_fail++; $display("FAIL stats_hold got=%0h/%0h exp=f/0", br_count, br_taken_count); end
    stall = 0; flush = 0;
    tick();
    n_checks++; if ({br_count, br_taken_count} !== {4'h0, 4'h1}) begin
      n_fail++; $display("FAIL stats_wrap got=%0h/%0h exp=0/1", br_count, br_taken_count); end
    clear_inputs();
  endtask
`endif

  initial begin
    clear_inputs();
    test_reset();
    test_setflags_bcond();
    test_stall();
    test_flush();
    test_bubble();
    test_cbz_cbnz();
    test_conds();
`ifdef BRANCH_STATS_EN
    test_stats();
`endif
    rst = 1;
    tick();
    clear_inputs();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
